// File: rtl/cgra_kernel_sequencer.sv
// Kernel run sequencer for the PE torus.
// Detects a rising edge on Computation_Start and then walks through
// PRELOAD, RUN and DRAIN before raising Computation_Done. In RUN it broadcasts
// the instruction address to every PE and repeats the kernel body Iter_Num
// times with no gap between iterations. Done is held until Start drops.
module cgra_kernel_sequencer #(
    parameter int INST_AWIDTH = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 4
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Computation_Start,
    input  logic [INST_AWIDTH:0]   Kernel_Len,
    input  logic [CNT_WIDTH-1:0]   Iter_Num,
    output logic [INST_AWIDTH-1:0] Inst_Addr,
    output logic                   Inst_Rd_En,
    output logic [CNT_WIDTH-1:0]   Iter_Cnt,
    output logic                   PE_Array_Busy,
    output logic                   Computation_Done
);

    localparam int PH_MAX = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]      PRE_LAST  = PH_W'(PRE_CYCLES - 1);
    localparam logic [PH_W-1:0]      POST_LAST = PH_W'(POST_CYCLES - 1);
    localparam logic [INST_AWIDTH:0] LEN_MAX   = {1'b1, {INST_AWIDTH{1'b0}}};
    localparam logic [INST_AWIDTH:0] LEN_ONE   = (INST_AWIDTH + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] ITER_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   start_prev_q;
    logic [INST_AWIDTH:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   iters_q, iters_d;
    logic [PH_W-1:0]        ph_q, ph_d;
    logic [INST_AWIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   iter_q, iter_d;
    logic                   rd_en_q, rd_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   start_pulse;
    logic [INST_AWIDTH:0]   len_sat;
    logic [INST_AWIDTH:0]   len_last;
    logic [CNT_WIDTH-1:0]   iters_last;

    // Next-state, counters and the registered output values.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        iters_d     = iters_q;
        ph_d        = ph_q;
        addr_d      = addr_q;
        iter_d      = iter_q;

        start_pulse = Computation_Start & ~start_prev_q;
        len_sat     = (Kernel_Len > LEN_MAX) ? LEN_MAX : Kernel_Len;
        len_last    = len_q - LEN_ONE;
        iters_last  = iters_q - ITER_ONE;

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                iter_d = '0;
                ph_d   = '0;
                if (start_pulse) begin
                    len_d   = len_sat;
                    iters_d = (Iter_Num == '0) ? ITER_ONE : Iter_Num;
                    // An empty kernel has nothing to fetch; only the drain runs.
                    state_d = (len_sat == '0) ? S_DRAIN : S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (ph_q == PRE_LAST) begin
                    ph_d    = '0;
                    state_d = S_RUN;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_RUN: begin
                // The wrap is decided by the latched length, so a 2^AW kernel
                // reaches the top address without an early counter overflow.
                if ({1'b0, addr_q} == len_last) begin
                    if (iter_q == iters_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = '0;
                        iter_d = iter_q + 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (ph_q == POST_LAST) begin
                    ph_d    = '0;
                    state_d = S_DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!Computation_Start) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    iter_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_RUN);
        busy_d  = (state_d == S_PRELOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
    end

    // State register; start history resets high so a level held through reset is not a start.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            start_prev_q <= Computation_Start;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            len_q   <= '0;
            iters_q <= '0;
            ph_q    <= '0;
            addr_q  <= '0;
            iter_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            len_q   <= len_d;
            iters_q <= iters_d;
            ph_q    <= ph_d;
            addr_q  <= addr_d;
            iter_q  <= iter_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Inst_Addr        = addr_q;
    assign Inst_Rd_En       = rd_en_q;
    assign Iter_Cnt         = iter_q;
    assign PE_Array_Busy    = busy_q;
    assign Computation_Done = done_q;

endmodule

// File: tb/tb_cgra_kernel_sequencer.sv
// Directed bench for cgra_kernel_sequencer with default parameters
// (INST_AWIDTH=8, CNT_WIDTH=16, PRE_CYCLES=2, POST_CYCLES=4).
module tb_cgra_kernel_sequencer;

    localparam int AW = 8;
    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Resetn;
    logic          Computation_Start;
    logic [AW:0]   Kernel_Len;
    logic [CW-1:0] Iter_Num;
    logic [AW-1:0] Inst_Addr;
    logic          Inst_Rd_En;
    logic [CW-1:0] Iter_Cnt;
    logic          PE_Array_Busy;
    logic          Computation_Done;

    int checks = 0;
    int errors = 0;

    cgra_kernel_sequencer dut (
        .Clk               (Clk),
        .Resetn            (Resetn),
        .Computation_Start (Computation_Start),
        .Kernel_Len        (Kernel_Len),
        .Iter_Num          (Iter_Num),
        .Inst_Addr         (Inst_Addr),
        .Inst_Rd_En        (Inst_Rd_En),
        .Iter_Cnt          (Iter_Cnt),
        .PE_Array_Busy     (PE_Array_Busy),
        .Computation_Done  (Computation_Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // mode 0: hold Start until Done; 1: one-cycle Start; 2: Start toggled mid-run
    typedef struct {
        int    len;
        int    iters;
        int    mode;
        int    exp_busy;
        int    exp_rd;
        string name;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lsat, itf, busy, rd, bad;
        bit seen_done;
        lsat = (v.len > 256) ? 256 : v.len;
        itf  = (v.iters == 0) ? 1 : v.iters;
        busy = 0; rd = 0; bad = 0; seen_done = 1'b0;
        @(negedge Clk);
        Kernel_Len        = (AW + 1)'(v.len);
        Iter_Num          = CW'(v.iters);
        Computation_Start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            // Latched values must not follow later input changes.
            Kernel_Len = 9'd7;
            Iter_Num   = 16'd9;
            if (Computation_Done) begin
                seen_done = 1'b1;
                break;
            end
            if (PE_Array_Busy) busy++;
            if (Inst_Rd_En) begin
                if (lsat == 0) bad++;
                else if (Inst_Addr !== AW'(rd % lsat) || Iter_Cnt !== CW'(rd / lsat)) bad++;
                rd++;
            end else if (PE_Array_Busy) begin
                if (rd == 0) begin
                    if (Inst_Addr !== '0 || Iter_Cnt !== '0) bad++;
                end else if (Inst_Addr !== AW'(lsat - 1) || Iter_Cnt !== CW'(itf - 1)) begin
                    bad++;
                end
            end
            if (v.mode != 0 && busy == 1) Computation_Start = 1'b0;
            if (v.mode == 2 && busy == 3) Computation_Start = 1'b1;
            if (v.mode == 2 && busy == 6) Computation_Start = 1'b0;
        end
        check({v.name, " done seen"}, seen_done, 1);
        check({v.name, " busy cycles"}, busy, v.exp_busy);
        check({v.name, " rd_en cycles"}, rd, v.exp_rd);
        check({v.name, " addr/iter sequence errors"}, bad, 0);
        check({v.name, " busy low at done"}, PE_Array_Busy, 0);
        if (v.mode == 0) begin
            repeat (3) @(negedge Clk);
            check({v.name, " done held"}, Computation_Done, 1);
            Computation_Start = 1'b0;
        end
        @(negedge Clk);
        check({v.name, " done dropped"}, Computation_Done, 0);
        check({v.name, " idle addr"}, Inst_Addr, 0);
        check({v.name, " idle iter"}, Iter_Cnt, 0);
        repeat (3) @(negedge Clk);
        check({v.name, " no queued restart"}, PE_Array_Busy, 0);
    endtask

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_busy;
        bit hit;

        vecs[0] = '{5,   2, 0, 16,  10,  "T1 len5 x2 held"};
        vecs[1] = '{0,   7, 1, 4,   0,   "T2 len0 x7"};
        vecs[2] = '{3,   0, 1, 9,   3,   "T3 len3 iter0"};
        vecs[3] = '{5,   2, 2, 16,  10,  "T4 toggle mid-run"};
        vecs[4] = '{1,   3, 1, 9,   3,   "len1 x3"};
        vecs[5] = '{256, 1, 1, 262, 256, "T6 len256"};
        vecs[6] = '{300, 1, 0, 262, 256, "T6 len300 sat"};
        vecs[7] = '{511, 2, 1, 518, 512, "len511 sat x2"};

        // Reset with Start already high.
        Resetn            = 1'b0;
        Computation_Start = 1'b1;
        Kernel_Len        = 9'd5;
        Iter_Num          = 16'd2;
        repeat (3) @(negedge Clk);
        check("reset busy", PE_Array_Busy, 0);
        check("reset done", Computation_Done, 0);
        check("reset rd_en", Inst_Rd_En, 0);
        check("reset addr", Inst_Addr, 0);
        check("reset iter", Iter_Cnt, 0);
        Resetn   = 1'b1;
        any_busy = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (PE_Array_Busy) any_busy = 1'b1;
        end
        check("start held through reset ignored", any_busy, 0);
        Computation_Start = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of RUN at address 2.
        @(negedge Clk);
        Kernel_Len        = 9'd5;
        Iter_Num          = 16'd2;
        Computation_Start = 1'b1;
        hit               = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            Computation_Start = 1'b0;
            if (Inst_Rd_En && Inst_Addr == 8'd2) begin
                hit = 1'b1;
                break;
            end
        end
        check("T5 reached addr 2", hit, 1);
        Resetn = 1'b0;
        #1;
        check("T5 async busy", PE_Array_Busy, 0);
        check("T5 async addr", Inst_Addr, 0);
        check("T5 async done", Computation_Done, 0);
        check("T5 async rd_en", Inst_Rd_En, 0);
        @(negedge Clk);
        Resetn = 1'b1;
        @(negedge Clk);
        run_vec('{3, 2, 1, 12, 6, "T5 rerun len3 x2"});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
